gpio_irq_wb: RTL

Parametrised Wishbone GPIO controller with per-pin direction and output registers, an atomic output-toggle register, and per-pin rising/falling edge capture with a combined interrupt line. It sits on the SoC peripheral bus beside the other `_wb` peripherals and drives up to 32 package pins through registered `SB_IO` cells. It supersedes the plain OE/OUT/IN GPIO block for designs that need event detection without polling.

---
 rtl/gpio_irq_wb.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/gpio_irq_wb.sv
// ============================================================================
// Module   : gpio_irq_wb
// Brief    : Wishbone GPIO with direction/output/toggle registers, per-pin
//            rising/falling edge capture (W1C status) and a level interrupt.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module gpio_irq_wb #(
    parameter int N = 12
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire [N-1:0] gpio,
    input  logic [31:0] wb_wdata,
    output logic [31:0] wb_rdata,
    input  logic [2:0]  wb_addr,
    input  logic        wb_we,
    input  logic        wb_cyc,
    output logic        wb_ack,
    output logic        irq
);

    localparam logic [2:0] c_ADDR_OE      = 3'd0;
    localparam logic [2:0] c_ADDR_OUT     = 3'd1;
    localparam logic [2:0] c_ADDR_IN      = 3'd2;
    localparam logic [2:0] c_ADDR_TGL     = 3'd3;
    localparam logic [2:0] c_ADDR_RISE_EN = 3'd4;
    localparam logic [2:0] c_ADDR_FALL_EN = 3'd5;
    localparam logic [2:0] c_ADDR_STATUS  = 3'd6;

    // Software-visible registers
    logic [N-1:0] r_oe;
    logic [N-1:0] r_out;
    logic [N-1:0] r_rise_en;
    logic [N-1:0] r_fall_en;
    logic [N-1:0] r_status;

    // Pad registers (the registered SB_IO output/enable/input flops)
    logic [N-1:0] r_pad_oe;
    logic [N-1:0] r_pad_out;
    logic [N-1:0] r_gpio_i;
    logic [N-1:0] r_gpio_p;
    logic         r_armed;

    // Registered write strobe with its captured address and data
    logic         r_wr_stb;
    logic [2:0]   r_wr_addr;
    logic [N-1:0] r_wr_data;

    logic         w_bus_clr;
    logic [31:0]  w_rd_mux;
    logic [N-1:0] w_rise;
    logic [N-1:0] w_fall;
    logic [N-1:0] w_event;
    logic [N-1:0] w_w1c;
    logic         w_unused;

    assign w_unused  = &{1'b0, wb_wdata};
    assign w_bus_clr = ~wb_cyc | wb_ack;

    // ------------------------------------------------------------------
    // Pad cells: output and enable registered, input registered
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N; gi++) begin : g_pin
        assign gpio[gi] = r_pad_oe[gi] ? r_pad_out[gi] : 1'bz;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pad_oe  <= '0;
            r_pad_out <= '0;
        end else begin
            r_pad_oe  <= r_oe;
            r_pad_out <= r_out;
        end
    end

    // gpio_p keeps following gpio_i through reset so the first armed cycle
    // compares two samples of the same static level and sees no edge.
    always_ff @(posedge clk) begin
        r_gpio_i <= gpio;
        r_gpio_p <= r_gpio_i;
        if (rst) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    assign w_rise  = r_gpio_i & ~r_gpio_p;
    assign w_fall  = ~r_gpio_i & r_gpio_p;
    assign w_event = r_armed ? ((w_rise & r_rise_en) | (w_fall & r_fall_en)) : '0;

    // ------------------------------------------------------------------
    // Bus handshake: one strobe per transaction, ack every other cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack    <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            wb_ack   <= wb_cyc & ~wb_ack;
            r_wr_stb <= ~w_bus_clr & wb_we;
            if (!w_bus_clr) begin
                r_wr_addr <= wb_addr;
                r_wr_data <= wb_wdata[N-1:0];
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (wb_addr)
            c_ADDR_OE:      w_rd_mux[N-1:0] = r_oe;
            c_ADDR_OUT:     w_rd_mux[N-1:0] = r_out;
            c_ADDR_IN:      w_rd_mux[N-1:0] = r_gpio_i;
            c_ADDR_RISE_EN: w_rd_mux[N-1:0] = r_rise_en;
            c_ADDR_FALL_EN: w_rd_mux[N-1:0] = r_fall_en;
            c_ADDR_STATUS:  w_rd_mux[N-1:0] = r_status;
            default:        w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || w_bus_clr) begin
            wb_rdata <= '0;
        end else begin
            wb_rdata <= w_rd_mux;
        end
    end

    // ------------------------------------------------------------------
    // Register writes
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_oe      <= '0;
            r_out     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else if (r_wr_stb) begin
            case (r_wr_addr)
                c_ADDR_OE:      r_oe      <= r_wr_data;
                c_ADDR_OUT:     r_out     <= r_wr_data;
                c_ADDR_TGL:     r_out     <= r_out ^ r_wr_data;
                c_ADDR_RISE_EN: r_rise_en <= r_wr_data;
                c_ADDR_FALL_EN: r_fall_en <= r_wr_data;
                default:        ;
            endcase
        end
    end

    assign w_w1c = (r_wr_stb && (r_wr_addr == c_ADDR_STATUS)) ? r_wr_data : '0;

    // A new event is OR-ed in after the clear, so it wins a same-cycle W1C.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_status <= '0;
            irq      <= 1'b0;
        end else begin
            r_status <= (r_status & ~w_w1c) | w_event;
            irq      <= |r_status;
        end
    end

endmodule

`default_nettype wire
